// File: rtl/strobe_arbiter.sv
// Round-robin arbiter sharing one edge-gated write strobe among N_REQ requesters.
// Optional post-ack guard interval enabled by defining STROBE_GUARD_EN.
module strobe_arbiter #(
    parameter int  N_REQ        = 4,
    parameter int  GUARD_CYCLES = 2,
    localparam int IDX_W        = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             strobe_en,
    output logic [N_REQ-1:0] sel,
    output logic [N_REQ-1:0] ack,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACK   = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               r_strobe;
    logic [N_REQ-1:0]   r_sel;
    logic [N_REQ-1:0]   r_ack;
    logic [IDX_W-1:0]   r_gidx;
    logic               r_busy;
    logic               w_strobe_nxt;
    logic [N_REQ-1:0]   w_sel_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic [IDX_W-1:0]   w_gidx_nxt;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [N_REQ-1:0]   w_onehot;

`ifdef STROBE_GUARD_EN
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int GLOAD = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
    logic [GW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ACK) begin
            r_cnt <= GW'(GLOAD);
        end else if (r_state == GUARD && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
`endif

    // Search upward from the pointer, wrapping N_REQ-1 to 0.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(j);
            end
        end
    end

    assign w_onehot = N_REQ'(1) << w_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_strobe <= 1'b0;
            r_sel    <= '0;
            r_ack    <= '0;
            r_gidx   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_strobe <= w_strobe_nxt;
            r_sel    <= w_sel_nxt;
            r_ack    <= w_ack_nxt;
            r_gidx   <= w_gidx_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: w_state_nxt = ACK;
            ACK: begin
`ifdef STROBE_GUARD_EN
                w_state_nxt = (GUARD_CYCLES > 0) ? GUARD : IDLE;
`else
                w_state_nxt = IDLE;
`endif
            end
            GUARD: begin
`ifdef STROBE_GUARD_EN
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port is a flop.
    always_comb begin
        w_strobe_nxt = 1'b0;
        w_sel_nxt    = r_sel;
        w_ack_nxt    = '0;
        w_gidx_nxt   = r_gidx;
        w_ptr_nxt    = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_strobe_nxt = 1'b1;
                    w_sel_nxt    = w_onehot;
                    w_gidx_nxt   = w_win;
                end
            end
            ARM: w_ack_nxt = r_sel;
            ACK: begin
                w_sel_nxt = '0;
                if (r_gidx == IDX_W'(N_REQ - 1)) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_gidx + 1'b1;
                end
            end
            default: w_sel_nxt = '0;
        endcase
    end

    assign strobe_en = r_strobe;
    assign sel       = r_sel;
    assign ack       = r_ack;
    assign grant_idx = r_gidx;
    assign busy      = r_busy;

endmodule

// File: tb/tb_strobe_arbiter.sv
// Directed-vector bench for strobe_arbiter (N_REQ=4).
// Vector rows assume the default build; spacing checks follow STROBE_GUARD_EN.
module tb_strobe_arbiter;

`ifdef STROBE_GUARD_EN
    localparam int SPACING = 5;
`else
    localparam int SPACING = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       strobe_en;
    logic [3:0] sel;
    logic [3:0] ack;
    logic [1:0] grant_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    strobe_arbiter #(.N_REQ(4), .GUARD_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .strobe_en(strobe_en),
        .sel      (sel),
        .ack      (ack),
        .grant_idx(grant_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       strobe;
        logic [3:0] sel;
        logic [3:0] ack;
        logic [1:0] gidx;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq,
                       input logic st, input logic [3:0] sl,
                       input logic [3:0] ak, input logic [1:0] gi,
                       input logic bz);
        vec_t v;
        v.rst_n = r; v.req = rq; v.strobe = st; v.sel = sl;
        v.ack = ak; v.gidx = gi; v.busy = bz;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic invariants();
        checks++;
        if (!$onehot0(sel) || !$onehot0(ack) || (strobe_en && (ack != 0))) begin
            errors++;
            $display("FAIL invariant: strobe=%b sel=%b ack=%b",
                     strobe_en, sel, ack);
        end
    endtask

    initial begin
        int   ngrant;
        int   nack;
        int   last_edge;
        int   order[4];
        int   cyc;
        logic [3:0] rq;
        logic [11:0] got, exp;

        rst_n = 1'b0;
        req   = 4'b0;

        // reset with all requesting, then first grant to 0
        add(0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b1111, 1, 4'b0001, 4'b0000, 0, 1);
        add(1, 4'b1111, 0, 4'b0001, 4'b0001, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // single request on 2, dropped mid-grant
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 2, 1);
        add(1, 4'b0000, 0, 4'b0100, 4'b0100, 2, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0);
        // ptr=3, req=1001 -> 3 then 0
        add(1, 4'b1001, 1, 4'b1000, 4'b0000, 3, 1);
        add(1, 4'b1001, 0, 4'b1000, 4'b1000, 3, 1);
        add(1, 4'b0001, 0, 4'b0000, 4'b0000, 3, 0);
        add(1, 4'b0001, 1, 4'b0001, 4'b0000, 0, 1);
        add(1, 4'b0001, 0, 4'b0001, 4'b0001, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // reset during ARM: no ack, ptr back to 0
        add(1, 4'b0010, 1, 4'b0010, 4'b0000, 1, 1);
        add(0, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0011, 1, 4'b0001, 4'b0000, 0, 1);
        add(1, 4'b0011, 0, 4'b0001, 4'b0001, 0, 1);
        add(1, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0);
        // grant 2 -> ptr=3; req[3]=0 wraps to bit 0
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 2, 1);
        add(1, 4'b0100, 0, 4'b0100, 4'b0100, 2, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0);
        add(1, 4'b0011, 1, 4'b0001, 4'b0000, 0, 1);
        add(1, 4'b0011, 0, 4'b0001, 4'b0001, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            @(posedge clk);
            #1;
            got = {strobe_en, sel, ack, grant_idx, busy};
            exp = {vecs[i].strobe, vecs[i].sel, vecs[i].ack,
                   vecs[i].gidx, vecs[i].busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vec%0d: st/sel/ack/gi/busy got %b %b %b %0d %b expected %b %b %b %0d %b",
                         i, strobe_en, sel, ack, grant_idx, busy,
                         vecs[i].strobe, vecs[i].sel, vecs[i].ack,
                         vecs[i].gidx, vecs[i].busy);
            end
        end

        // all four request, each drops after its ack
        rst_n = 1'b0;
        req   = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rq        = 4'b1111;
        req       = rq;
        ngrant    = 0;
        nack      = 0;
        last_edge = -1;
        cyc       = 0;
        while ((rq != 0 || busy) && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            invariants();
            if (strobe_en) begin
                if (ngrant < 4) order[ngrant] = int'(grant_idx);
                if (last_edge >= 0) chk("rr_spacing", cyc - last_edge, SPACING);
                last_edge = cyc;
                ngrant++;
            end
            if (ack != 0) begin
                nack++;
                rq  = rq & ~ack;
                req = rq;
            end
        end
        chk("rr_timeout", (cyc < 60) ? 1 : 0, 1);
        chk("rr_grants", ngrant, 4);
        chk("rr_acks", nack, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ngrant) chk($sformatf("rr_order%0d", i), order[i], i);
        end

        // req=0011 held: grants alternate 0,1 with fixed spacing
        req       = 4'b0011;
        ngrant    = 0;
        last_edge = -1;
        cyc       = 0;
        while (ngrant < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            invariants();
            if (strobe_en) begin
                chk($sformatf("hold_idx%0d", ngrant), int'(grant_idx), ngrant % 2);
                if (last_edge >= 0) chk("hold_spacing", cyc - last_edge, SPACING);
                last_edge = cyc;
                ngrant++;
            end
        end
        chk("hold_timeout", (cyc < 40) ? 1 : 0, 1);
        req = 4'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("final_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
